// File: rtl/mem_bank_playback.sv
// mem_bank_playback: streams a burst of words from a 2-cycle-latency memory bank through a 4-entry FIFO; optional abort via MEM_BANK_PLAYBACK_ABORT_EN
module mem_bank_playback #(
  parameter int WORD_LENGTH = 24,
  parameter int ADDR_WIDTH  = 13,
  parameter int NUM_WORDS   = 8192
) (
`ifdef MEM_BANK_PLAYBACK_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [ADDR_WIDTH:0]    length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic                   mem_wren,
  input  logic [WORD_LENGTH-1:0] mem_q,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cur, last, iaddr;
  logic [ADDR_WIDTH:0] rem, rem_n;
  logic p1, p2, abort_i, kill, accept, space, issue, push, pop, done_n;
  logic [WORD_LENGTH-1:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt, cnt_n;
`ifdef MEM_BANK_PLAYBACK_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif
  assign kill = abort_i && state != IDLE;
  assign accept = state == IDLE && start && !abort_i;
  // p1/p2 track reads one and two cycles old; counting them reserves FIFO room
  assign space = (cnt + {2'b0, p1} + {2'b0, p2}) < 3'd4;
  assign issue = !kill && space && (accept ? length != '0 : (state == RUN && rem != '0));
  // the first address goes out in the start cycle itself so data lands three cycles later
  assign iaddr = accept ? start_addr : cur;
  assign mem_address = issue ? iaddr : last;
  assign mem_wren = 1'b0;
  assign rem_n = (accept ? length : rem) - {{ADDR_WIDTH{1'b0}}, issue};
  assign push = p2;
  assign out_valid = cnt != 3'd0;
  assign out_data = out_valid ? fifo[rp] : '0;
  assign pop = out_valid && out_ready;
  assign cnt_n = cnt + {2'b0, push} - {2'b0, pop};
  assign busy = state != IDLE;
  // next-state selection and completion detection
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    if (state == IDLE) state_n = (accept && length != '0) ? RUN : IDLE;
    if (state == RUN) state_n = (rem_n == '0) ? DRAIN : RUN;
    if (state == DRAIN) state_n = (cnt_n == 3'd0 && !p1 && !p2) ? IDLE : DRAIN;
    done_n = !kill && ((accept && length == '0) || (state == DRAIN && state_n == IDLE));
    if (kill) state_n = IDLE;
  end
  // state, address, in-flight pipeline and FIFO registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      done <= 1'b0;
      cur <= '0;
      last <= '0;
      rem <= '0;
      p1 <= 1'b0;
      p2 <= 1'b0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_n;
      done <= done_n;
      rem <= rem_n;
      p1 <= issue;
      p2 <= p1 && !kill;
      if (issue) begin
        cur <= (iaddr == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : iaddr + ADDR_WIDTH'(1);
        last <= iaddr;
      end
      if (kill) begin
        cnt <= '0;
        wp <= '0;
        rp <= '0;
      end else begin
        cnt <= cnt_n;
        if (push) begin
          fifo[wp] <= mem_q;
          wp <= wp + 2'd1;
        end
        if (pop) rp <= rp + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_bank_playback.sv
// tb_mem_bank_playback: directed self-checking bench for mem_bank_playback with a 2-cycle memory model
module tb_mem_bank_playback;
  logic clock = 0, reset_n = 0, start = 0, out_ready = 0;
  logic [12:0] start_addr = 0;
  logic [13:0] length = 0;
  logic busy, done, mem_wren, out_valid;
  logic [12:0] mem_address;
  logic [23:0] mem_q = 0, out_data, s1 = 0;
`ifdef MEM_BANK_PLAYBACK_ABORT_EN
  logic abort = 0;
`endif
  int n_cmp = 0, n_fail = 0;

  mem_bank_playback dut (
`ifdef MEM_BANK_PLAYBACK_ABORT_EN
    .abort(abort),
`endif
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_wren(mem_wren), .mem_q(mem_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clock = ~clock;

  function automatic logic [23:0] f(input logic [12:0] a);
    return {~a[10:0], a};
  endfunction

  // two-register memory: address in cycle N gives data in cycle N+2
  always @(posedge clock) begin
    s1 <= f(mem_address);
    mem_q <= s1;
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    cyc;
    cyc;
    #1;
    n_cmp++;
    if ({busy, done, out_valid, mem_wren} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, out_valid, mem_wren});
    end
    n_cmp++;
    if ({out_data, mem_address} !== 37'b0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0/0", out_data, mem_address);
    end
    reset_n = 1;
  endtask

  task automatic test_basic;
    cyc;
    start = 1; start_addr = 13'h0010; length = 4; out_ready = 1;
    #1;
    n_cmp++;
    if (mem_address !== 13'h0010) begin
      n_fail++;
      $display("FAIL basic_addr0 got %h want 0010", mem_address);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc;
      start = 0;
      #1;
      n_cmp++;
      if ({busy, done, out_valid} !== {k <= 6, k == 7, k >= 3 && k <= 6}) begin
        n_fail++;
        $display("FAIL basic_flags cyc %0d got %b want %b", k, {busy, done, out_valid},
                 {k <= 6, k == 7, k >= 3 && k <= 6});
      end
      if (k >= 3 && k <= 6) begin
        n_cmp++;
        if (out_data !== f(13'(16 + k - 3))) begin
          n_fail++;
          $display("FAIL basic_data cyc %0d got %h want %h", k, out_data, f(13'(16 + k - 3)));
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [12:0] ea;
    cyc;
    start = 1; start_addr = 13'h1FFE; length = 4;
    #1;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin
        cyc;
        start = 0;
        #1;
      end
      ea = (k < 4) ? 13'(14'h1FFE + k) : 13'h0001;
      n_cmp++;
      if (mem_address !== ea) begin
        n_fail++;
        $display("FAIL wrap_addr cyc %0d got %h want %h", k, mem_address, ea);
      end
      if (k >= 3 && k <= 6) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== f(13'(14'h1FFE + k - 3))) begin
          n_fail++;
          $display("FAIL wrap_data cyc %0d got %b/%h want 1/%h", k, out_valid, out_data,
                   f(13'(14'h1FFE + k - 3)));
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_done got %b want 1", done);
        end
      end
    end
  endtask

  task automatic test_stall;
    int iss = 0, xf = 0;
    logic prev_stall = 0, got_done = 0;
    logic [23:0] prev_data = 0;
    cyc;
    start = 1; start_addr = 13'h0100; length = 16; out_ready = 1;
    for (int k = 0; k < 80 && !got_done; k++) begin
      if (k > 0) begin
        cyc;
        start = 0;
        out_ready = !(k >= 5 && k < 15);
      end
      #1;
      if (iss < 16 && mem_address == 13'(256 + iss)) iss++;
      n_cmp++;
      if (iss - xf > 4) begin
        n_fail++;
        $display("FAIL stall_outstanding cyc %0d got %0d want <=4", k, iss - xf);
      end
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d got %b/%h want 1/%h", k, out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== f(13'(256 + xf))) begin
          n_fail++;
          $display("FAIL stall_data word %0d got %h want %h", xf, out_data, f(13'(256 + xf)));
        end
        xf++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      got_done = done;
    end
    n_cmp++;
    if (xf != 16 || !got_done || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_total got %0d words done=%b busy=%b want 16 words done=1 busy=0",
               xf, got_done, busy);
    end
  endtask

  task automatic test_zero;
    cyc;
    start = 1; start_addr = 13'h0ABC; length = 0; out_ready = 1;
    #1;
    n_cmp++;
    if (mem_address !== 13'h010F || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_issue got %h busy=%b want 010F busy=0", mem_address, busy);
    end
    cyc;
    start = 0;
    #1;
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100 || mem_address !== 13'h010F) begin
      n_fail++;
      $display("FAIL zero_done got %b addr %h want 100 addr 010F", {done, busy, out_valid}, mem_address);
    end
    for (int k = 0; k < 4; k++) begin
      cyc;
      #1;
      n_cmp++;
      if ({done, busy, out_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL zero_after got %b want 000", {done, busy, out_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    cyc;
    start = 1; start_addr = 13'h0300; length = 3; out_ready = 1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      cyc;
      start = (k == 2);
      start_addr = 0;
      length = 5;
      #1;
      n_cmp++;
      if ({busy, done, out_valid} !== {k <= 5, k == 6, k >= 3 && k <= 5}) begin
        n_fail++;
        $display("FAIL b2b_flags cyc %0d got %b want %b", k, {busy, done, out_valid},
                 {k <= 5, k == 6, k >= 3 && k <= 5});
      end
      if (k >= 3 && k <= 5) begin
        n_cmp++;
        if (out_data !== f(13'(768 + k - 3))) begin
          n_fail++;
          $display("FAIL b2b_data cyc %0d got %h want %h", k, out_data, f(13'(768 + k - 3)));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int xf = 0;
    logic got_done = 0;
    cyc;
    start = 1; start_addr = 13'h0040; length = 8; out_ready = 1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      cyc;
      start = 0;
      if (k == 6) begin
        out_ready = 0;
        reset_n = 0;
      end
      #1;
      if (out_valid && out_ready) xf++;
    end
    n_cmp++;
    if (xf != 3) begin
      n_fail++;
      $display("FAIL rmid_pre got %0d words want 3", xf);
    end
    cyc;
    reset_n = 1;
    out_ready = 1;
    #1;
    n_cmp++;
    if ({busy, done, out_valid, mem_wren, out_data, mem_address} !== 41'b0) begin
      n_fail++;
      $display("FAIL rmid_reset got %b %h %h want all zero", {busy, done, out_valid, mem_wren},
               out_data, mem_address);
    end
    for (int k = 0; k < 6; k++) begin
      cyc;
      #1;
      n_cmp++;
      if ({done, out_valid, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rmid_quiet cyc %0d got %b want 000", k, {done, out_valid, busy});
      end
    end
    xf = 0;
    cyc;
    start = 1; start_addr = 13'h0200; length = 2;
    for (int k = 0; k < 20 && !got_done; k++) begin
      if (k > 0) begin
        cyc;
        start = 0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== f(13'(512 + xf))) begin
          n_fail++;
          $display("FAIL rmid_data word %0d got %h want %h", xf, out_data, f(13'(512 + xf)));
        end
        xf++;
      end
      got_done = done;
    end
    n_cmp++;
    if (xf != 2 || !got_done) begin
      n_fail++;
      $display("FAIL rmid_total got %0d words done=%b want 2 done=1", xf, got_done);
    end
  endtask

`ifdef MEM_BANK_PLAYBACK_ABORT_EN
  task automatic test_abort;
    cyc;
    start = 1; start_addr = 13'h0500; length = 2; out_ready = 0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      cyc;
      start = 0;
      #1;
    end
    n_cmp++;
    if ({out_valid, busy} !== 2'b11 || out_data !== f(13'h0500)) begin
      n_fail++;
      $display("FAIL abort_pre got %b %h want 11 %h", {out_valid, busy}, out_data, f(13'h0500));
    end
    abort = 1;
    cyc;
    abort = 0;
    #1;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_next got %b want 000", {out_valid, busy, done});
    end
    for (int k = 0; k < 5; k++) begin
      cyc;
      #1;
      n_cmp++;
      if ({out_valid, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_quiet cyc %0d got %b want 000", k, {out_valid, busy, done});
      end
    end
    cyc;
    start = 1; start_addr = 13'h0600; length = 2; out_ready = 1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      cyc;
      start = 0;
      #1;
      n_cmp++;
      if ({busy, done, out_valid} !== {k <= 4, k == 5, k >= 3 && k <= 4}) begin
        n_fail++;
        $display("FAIL abort_after cyc %0d got %b want %b", k, {busy, done, out_valid},
                 {k <= 4, k == 5, k >= 3 && k <= 4});
      end
      if (k >= 3 && k <= 4) begin
        n_cmp++;
        if (out_data !== f(13'(1536 + k - 3))) begin
          n_fail++;
          $display("FAIL abort_data cyc %0d got %h want %h", k, out_data, f(13'(1536 + k - 3)));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_zero;
    test_back_to_back;
    test_reset_mid;
`ifdef MEM_BANK_PLAYBACK_ABORT_EN
    test_abort;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bank_playback.md
MEM_BANK_PLAYBACK -- requirements
Module: mem_bank_playback

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 24, the memory word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 13, the memory address width in bits.
REQ-003 The block SHALL have parameter NUM_WORDS, default 8192, the number of words in the bank.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; one clock, reset is synchronous and active-low.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a playback burst.
REQ-007 The block SHALL have port start_addr, input, ADDR_WIDTH bits: the first word address of the burst.
REQ-008 The block SHALL have port length, input, ADDR_WIDTH+1 bits: the number of words to read, 0 to NUM_WORDS.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a burst is active.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse at burst completion.
REQ-011 The block SHALL have port mem_address, output, ADDR_WIDTH bits: the address to the memory bank.
REQ-012 The block SHALL have port mem_wren, output, 1 bit: the memory write enable, tied to 0.
REQ-013 The block SHALL have port mem_q, input, WORD_LENGTH bits: read data from the memory bank.
REQ-014 The block SHALL have port out_data, output, WORD_LENGTH bits: the streamed word.
REQ-015 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the word.

Function
REQ-017 The memory read latency SHALL be exactly 2 clocks: mem_q for the address driven in cycle N SHALL be captured in cycle N+2.
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE to RUN on start when length is nonzero.
- RUN to DRAIN once the last address has been issued.
- DRAIN to IDLE once the FIFO is empty and no reads are in flight.
REQ-019 A start with length 0 SHALL pulse done in the next cycle, issue no reads, and leave the FSM in IDLE.
REQ-020 A start while busy SHALL be ignored; start_addr and length SHALL be sampled only on an accepted start.
REQ-021 Addresses SHALL increment by 1 from start_addr and wrap from NUM_WORDS-1 to 0.
REQ-022 Returning words SHALL enter a 4-entry FIFO, with out_data/out_valid driven from the FIFO head.
REQ-023 A read SHALL be issued only when the FIFO occupancy plus reads in flight is less than 4, so the FIFO never overflows.
REQ-024 A word SHALL transfer on a cycle where out_valid and out_ready are both high.
REQ-025 Once out_valid is asserted, out_valid and out_data SHALL hold stable until the transfer occurs.
REQ-026 The FIFO SHALL support a push and a pop in the same cycle, leaving its occupancy unchanged.
REQ-027 Words SHALL be delivered in address order, exactly length words per burst.
REQ-028 With out_ready held high, the block SHALL sustain one word per clock after a 3-cycle initial latency (start to first out_valid).
REQ-029 busy SHALL rise the cycle after an accepted nonzero start.
REQ-030 busy SHALL fall in the same cycle done pulses, which is the cycle after the last word transfers.
REQ-031 mem_address SHALL hold its last value when no read is issued.

Reset
REQ-032 While reset_n is low at a clock edge, the block SHALL force the following values:
- FSM to IDLE;
- busy=0, done=0, out_valid=0;
- out_data=0, mem_address=0, mem_wren=0;
- FIFO and in-flight tracking cleared.
REQ-033 A reset mid-burst SHALL discard all buffered and in-flight words, with no done pulse and no out_valid until a new start.

Configuration
REQ-034 With macro MEM_BANK_PLAYBACK_ABORT_EN defined, the block SHALL add input port abort (1 bit).
- abort high in RUN or DRAIN: FSM returns to IDLE next cycle.
- FIFO flushed, in-flight words discarded, out_valid=0, busy=0, no done pulse.
- abort in IDLE: no effect.
- abort and start in the same cycle: abort wins and start is ignored.
REQ-035 Without MEM_BANK_PLAYBACK_ABORT_EN, the abort port SHALL NOT exist, and a burst SHALL always run to completion or reset.

Verification
REQ-036 start, start_addr=0x0010, length=4, out_ready=1 -> data from 0x10 to 0x13 in order on 4 consecutive out_valid cycles; first out_valid 3 cycles after start; done the cycle after the last transfer.
REQ-037 start_addr=0x1FFE, length=4 -> mem_address sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001 and matching data order.
REQ-038 length=16, out_ready low for 10 cycles mid-burst -> at most 4 words buffered, no word lost or duplicated, out_data stable while stalled, all 16 delivered.
REQ-039 length=0 -> done the next cycle, busy stays 0, no mem_address change, no out_valid.
REQ-040 reset_n low for 1 cycle mid-burst (length=8, after 3 transfers) -> all outputs at reset values next cycle, no done; a new start of length 2 delivers exactly 2 words.
REQ-041 MEM_BANK_PLAYBACK_ABORT_EN defined, abort during DRAIN with 2 words buffered -> out_valid=0 and busy=0 next cycle, no done, a subsequent burst is correct.
